// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Define FIFO_ARB_STALL_CNT_EN to add a saturating 16-bit count of owner cycles stalled by fifo_full.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST + 1);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  BURST_LAST = CW'(BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   owner_reg, owner_next;
  logic [IDW-1:0]   last_grant_reg, last_grant_next;
  logic [CW-1:0]    burst_cnt_reg, burst_cnt_next;

  logic [WIDTH-1:0] data_arr [NREQ];
  logic [WIDTH-1:0] owner_data;
  logic             owner_valid;
  logic             accept;
  logic [IDW-1:0]   pick;
  logic             pick_found;
  int               scan_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  assign owner_valid = req_valid[owner_reg];
  assign owner_data  = data_arr[owner_reg];
  assign grant_id    = owner_reg;

  // First valid requester strictly after the last grant, wrapping modulo NREQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(last_grant_reg) + k) % NREQ;
      if (!pick_found && req_valid[IDW'(scan_idx)]) begin
        pick       = IDW'(scan_idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    req_ready       = '0;
    fifo_wr_en      = 1'b0;
    fifo_din        = '0;
    grant_valid     = 1'b0;
    accept          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next      = OWN;
          owner_next      = pick;
          last_grant_next = pick;
          burst_cnt_next  = '0;
        end
      end
      OWN: begin
        grant_valid          = 1'b1;
        req_ready[owner_reg] = !fifo_full;
        accept               = owner_valid && !fifo_full;
        fifo_wr_en           = accept;
        if (accept) fifo_din = owner_data;
        // Full alone only freezes the burst; losing valid or finishing the burst releases.
        if (!owner_valid) begin
          state_next     = IDLE;
          burst_cnt_next = '0;
        end else if (accept) begin
          if (burst_cnt_reg == BURST_LAST) begin
            state_next     = IDLE;
            burst_cnt_next = '0;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= LAST_IDX;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == OWN && owner_valid && fifo_full && stall_cnt_reg != 16'hFFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int IDW   = 2;
  localparam int VW    = 1 + IDW + NREQ + 1 + WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full = 1'b0;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_din;
  logic                  grant_valid;
  logic [IDW-1:0]        grant_id;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Producer word queues; a producer is valid when unmasked and holding data.
  logic [WIDTH-1:0] src [NREQ][$];
  logic [NREQ-1:0]  vmask = '0;

  // Model: current owner (-1 when nobody owns), words taken in this grant, pointer.
  int m_owner, m_taken, m_ptr, m_gid, m_stall;
  int cyc;
  int wr_cyc[$];
  logic [WIDTH-1:0] wr_dat[$];
  int grants[$];
  logic [VW-1:0] exp_vec, obs_vec;

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_ptr   = NREQ - 1;
    m_gid   = 0;
    m_stall = 0;
  endtask

  task automatic clear_logs();
    cyc = 0;
    wr_cyc.delete();
    wr_dat.delete();
    grants.delete();
  endtask

  task automatic apply();
    logic [NREQ-1:0]  ev_rdy;
    logic             ev_wr;
    logic [WIDTH-1:0] ev_din;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = vmask[i] && (src[i].size() > 0);
      req_data[i*WIDTH +: WIDTH] = (src[i].size() > 0) ? src[i][0] : WIDTH'($urandom);
    end
    #1;
    ev_rdy = '0;
    ev_wr  = 1'b0;
    ev_din = '0;
    if (m_owner >= 0 && rst_n) begin
      ev_rdy = fifo_full ? '0 : (NREQ'(1) << m_owner);
      ev_wr  = req_valid[IDW'(m_owner)] && !fifo_full;
      if (ev_wr) ev_din = src[m_owner][0];
    end
    exp_vec = {(m_owner >= 0) && rst_n, IDW'(m_gid), ev_rdy, ev_wr, ev_din};
    obs_vec = {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din};
  endtask

  task automatic tick();
    int idx;
    @(posedge clk);
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req_valid[IDW'(idx)]) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_ptr   = m_owner;
        m_gid   = m_owner;
        m_taken = 0;
        grants.push_back(m_owner);
      end
    end else if (!req_valid[IDW'(m_owner)]) begin
      m_owner = -1;
    end else if (fifo_full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(src[m_owner].pop_front());
      m_taken++;
      if (m_taken == BURST) m_owner = -1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    vmask     = '0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) src[i].delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    vmask     = '1;
    for (int i = 0; i < NREQ; i++) begin
      src[i].delete();
      src[i].push_back(WIDTH'(8'h5A + i));
    end
    model_reset();
    clear_logs();
    apply();
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_outs got=%h want=%h", obs_vec, exp_vec);
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall got=%0d want=0", stall_cnt);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    apply();
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", obs_vec, exp_vec);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (grants.size() < 1 || grants[0] != 0) begin
      failures++;
      $display("FAIL reset_first_grant got=%0d want=0", (grants.size() > 0) ? grants[0] : -1);
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 6; k++) src[2].push_back(WIDTH'(8'hA0 + k));
    vmask = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (wr_dat.size() != 6 || grants.size() < 1 || grants[0] != 2) begin
      failures++;
      $display("FAIL single_count writes=%0d want=6 grants=%0d", wr_dat.size(), grants.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wr_dat[k] !== WIDTH'(8'hA0 + k) || wr_cyc[k] != ((k < 4) ? k + 1 : k + 2)) begin
          failures++;
          $display("FAIL single_word%0d got=%h@%0d want=%h@%0d", k, wr_dat[k], wr_cyc[k],
                   WIDTH'(8'hA0 + k), (k < 4) ? k + 1 : k + 2);
        end
      end
    end
    $display("test_single done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_all_valid();
    int n20;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 20; k++) src[i].push_back(WIDTH'(i * 32 + k));
    vmask = '1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL all_valid cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    n20 = 0;
    foreach (wr_cyc[k]) if (wr_cyc[k] < 20) n20++;
    checks++;
    if (n20 != 16) begin
      failures++;
      $display("FAIL all_valid_throughput got=%0d want=16", n20);
    end
    checks++;
    if (grants.size() < 5 || grants[0] != 0 || grants[1] != 1 || grants[2] != 2 ||
        grants[3] != 3 || grants[4] != 0) begin
      failures++;
      $display("FAIL all_valid_order got=%p want=0,1,2,3,0", grants);
    end
    $display("test_all_valid done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < 4; k++) src[1].push_back(WIDTH'(8'h10 + k));
    vmask = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      fifo_full = (cyc >= 3 && cyc <= 7);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL full_stall cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    fifo_full = 1'b0;
    checks++;
    if (wr_cyc.size() != 4) begin
      failures++;
      $display("FAIL full_stall_count got=%0d want=4", wr_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_cyc[k] != ((k < 2) ? k + 1 : k + 6) || wr_dat[k] !== WIDTH'(8'h10 + k)) begin
          failures++;
          $display("FAIL full_stall_word%0d got=%h@%0d want=%h@%0d", k, wr_dat[k], wr_cyc[k],
                   WIDTH'(8'h10 + k), (k < 2) ? k + 1 : k + 6);
        end
      end
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL full_stall_cnt got=%0d want=5", stall_cnt);
    end
`endif
    $display("test_full_stall done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_drop_valid();
    do_reset();
    src[3].push_back(8'h33);
    vmask = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cyc == 1) begin
        src[0].push_back(8'h01);
        src[1].push_back(8'h02);
      end
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL drop_valid cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (grants.size() != 3 || grants[0] != 3 || grants[1] != 0 || grants[2] != 1) begin
      failures++;
      $display("FAIL drop_valid_order got=%p want=3,0,1", grants);
    end
    $display("test_drop_valid done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 4; k++) src[2].push_back(WIDTH'(8'h20 + k));
    vmask = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL mid_burst cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (c < 2) tick();
    end
    rst_n = 1'b0;
    model_reset();
    apply();
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL mid_burst_async got=%h want=%h", obs_vec, exp_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    src[0].push_back(8'h44);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL mid_burst_after cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (grants.size() < 2 || grants[0] != 0 || grants[1] != 2) begin
      failures++;
      $display("FAIL mid_burst_order got=%p want=0,2", grants);
    end
    $display("test_reset_mid_burst done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full_at_grant();
    do_reset();
    for (int k = 0; k < 3; k++) src[0].push_back(WIDTH'(8'hC0 + k));
    vmask = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fifo_full = (cyc < 4);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL full_grant cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    fifo_full = 1'b0;
    checks++;
    if (wr_dat.size() != 3 || wr_cyc[0] != 4 || wr_dat[0] !== 8'hC0 || wr_dat[1] !== 8'hC1 ||
        wr_dat[2] !== 8'hC2) begin
      failures++;
      $display("FAIL full_grant_sb got=%p first=%0d want=c0,c1,c2 first=4", wr_dat,
               (wr_cyc.size() > 0) ? wr_cyc[0] : -1);
    end
    $display("test_full_at_grant done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int remaining;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 30; k++) src[i].push_back(WIDTH'($urandom));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      vmask     = NREQ'($urandom) | NREQ'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      apply();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    fifo_full = 1'b0;
    remaining = 0;
    for (int i = 0; i < NREQ; i++) remaining += src[i].size();
    checks++;
    if (wr_dat.size() + remaining != NREQ * 30) begin
      failures++;
      $display("FAIL random_conservation got=%0d want=%0d", wr_dat.size() + remaining, NREQ * 30);
    end
`ifdef FIFO_ARB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      failures++;
      $display("FAIL random_stall got=%0d want=%0d", stall_cnt, m_stall);
    end
`endif
    $display("test_random done: writes=%0d checks=%0d failures=%0d", wr_dat.size(), checks, failures);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_full_stall();
    test_drop_valid();
    test_reset_mid_burst();
    test_full_at_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one FIFO write port among NREQ producers. Each producer has a valid/ready interface. The block grants one producer at a time for a bounded burst of up to BURST words and drives the FIFO's wr_en/din from that producer. It respects the FIFO's full flag, so no write is issued while full is high, and no accepted word is ever lost.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, data width; must match the FIFO WIDTH
BURST, 4, maximum words per grant before forced re-arbitration (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  per-requester accept; a word transfers when valid&ready
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_din  out  WIDTH  FIFO write data
grant_valid  out  1  a requester currently owns the port
grant_id  out  $clog2(NREQ)  index of the owning requester

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE, grant_valid=0, grant_id=0, burst_cnt=0.
  - last_grant=NREQ-1, so requester 0 has highest priority after reset.
  - req_ready=0, fifo_wr_en=0, fifo_din=0.
- State machine with two states, IDLE and OWN. State, owner, burst_cnt and last_grant are registered.
- IDLE:
  - If any req_valid bit is high, select the first valid index scanning from last_grant+1 upward, modulo NREQ.
  - Next cycle: state=OWN, grant_id=selected, grant_valid=1, burst_cnt=0, last_grant=selected.
  - No writes are issued in IDLE. Grant latency from valid is 1 cycle.
- OWN, combinational outputs:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full.
  - fifo_din = req_data slice for grant_id, gated to 0 when fifo_wr_en=0.
- OWN, registered updates:
  - Each accepted word increments burst_cnt.
  - Return to IDLE (grant_valid=0) at the next edge when either:
    - a word is accepted with burst_cnt==BURST-1, or
    - req_valid[grant_id]=0 in the current cycle.
- Boundary conditions:
  - fifo_full high while owner is valid: the grant is held, burst_cnt is frozen, no write, no release. Full never forces a release.
  - Owner drops valid while full: release as normal (valid rule above).
  - Every release passes through IDLE, giving exactly 1 idle cycle between grants. Maximum write throughput is BURST/(BURST+1).
  - Simultaneous valids are resolved purely by the round-robin pointer. With all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0,...
  - Changes on a non-owner's req_valid never affect an ongoing grant.
  - rst_n asserted mid-burst: the burst is abandoned immediately. No wr_en is issued while rst_n=0. The pointer returns to NREQ-1.
  - burst_cnt width is $clog2(BURST+1); it never exceeds BURST-1.

Optional Feature:
Macro FIFO_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle in which state=OWN, req_valid[grant_id]=1 and fifo_full=1.
  - Saturates at 16'hFFFF. Cleared only by reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, only req_valid[2]=1 with data 0xA0..0xA5, FIFO never full, BURST=4 -> grant_id=2 one cycle after valid; words A0-A3 written on 4 consecutive cycles; 1 IDLE cycle; then A4-A5 written and release after req_valid drops.
- All four requesters continuously valid, FIFO never full -> grants in order 0,1,2,3,0. Each grant writes exactly 4 words, separated by 1 idle cycle; 16 words in 20 cycles.
- Requester 1 owns the port, fifo_full=1 for 5 cycles after 2 accepted words -> fifo_wr_en=0 and req_ready=0 for those 5 cycles, grant held. After full clears, 2 more words are written, then release. With the macro defined, stall_cnt=5.
- Requester 3 owns the port, drops valid after 1 word -> release next edge; pointer=3, so a pending requester 0 is granted next, ahead of requester 1.
- rst_n pulsed low mid-burst of requester 2 -> grant_valid, fifo_wr_en and req_ready go to 0 asynchronously. After release with requesters 0 and 2 valid, requester 0 is granted first.
- Requester 0 valid while fifo_full=1 at grant time -> grant issued, no writes while full. First word written in the cycle full deasserts; no data loss or duplication, checked against a FIFO scoreboard.
